five_bit_deser: RTL and testbench
=================================

# five_bit_deser

Serial-to-parallel front end that assembles framed serial bits into a 5-bit word for the 5-bit register stage directly downstream. Bits arrive one per `sin_en` strobe as start bit, five data bits (LSB first), optional parity and stop bit. Each good frame is presented on `word` with a valid/ready handshake. Malformed frames are dropped and flagged.

## Interface
- No parameters; word width is fixed at 5.
- `clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `sin` in 1: serial data, sampled only when `sin_en`=1.
- `sin_en` in 1: bit strobe, one bit per asserted cycle, any spacing.
- `word_ready` in 1: downstream accepts `word` this cycle.
- `word` out 5: assembled data, bit 0 = first data bit received.
- `word_valid` out 1: `word` holds an unconsumed good frame.
- `frame_err` out 1: one-cycle pulse, frame dropped.
- `overrun` out 1: one-cycle pulse, start bit arrived while a word was still held.
- `busy` out 1: a frame is in progress (DATA, PAR or STOP state).

## Operation
- States: IDLE, DATA, PAR (only with macro), STOP, HOLD. A 3-bit bit counter and a 5-bit shift register sit alongside.
- IDLE: on `sin_en`&`sin`=0 (start bit), go to DATA and clear the counter. `sin_en`&`sin`=1 is line idle and is ignored.
- DATA: on each `sin_en`, shift `sin` in at bit 4, so after 5 bits the first bit is at bit 0. Increment the counter. After the 5th bit, go to PAR if the macro is defined, else to STOP.
- PAR: on `sin_en`, compare `sin` to even parity (XOR of the 5 data bits). Match goes to STOP. Mismatch pulses `frame_err` and goes to IDLE.
- STOP: on `sin_en`, `sin`=1 loads `word` from the shift register and goes to HOLD. `sin`=0 pulses `frame_err` and goes to IDLE; `word` is unchanged.
- HOLD: `word_valid`=1 and `word` is stable. `word_valid`&`word_ready` is a transfer, then the state goes to IDLE.
- HOLD with no transfer and a start bit (`sin_en`&`sin`=0): pulse `overrun`, ignore the bit, stay in HOLD. Later bits of that frame are treated as idle or start bits under HOLD/IDLE rules.
- HOLD with a transfer and a start bit in the same cycle: the transfer completes, the start bit is accepted, and the state goes straight to DATA with the counter cleared. No overrun.
- `word_ready` outside HOLD has no effect.
- `busy`=1 exactly in DATA, PAR and STOP.

## Timing
- Reset: state=IDLE, counter=0, shift register=0, `word`=5'b0, `word_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. Reset takes effect immediately, independent of `clock`.
- Reset mid-frame or in HOLD discards all partial or held data. No error pulse is produced.
- `busy` rises the cycle after the start-bit strobe.
- `word_valid` rises the cycle after the accepted stop-bit strobe.
- `word_valid` falls the cycle after the transfer cycle.
- `frame_err` and `overrun` are registered, high for exactly the one cycle after the offending strobe.
- Minimum frame is 7 strobes without parity, 8 with. With strobes on consecutive cycles, a word is available 7 (8) cycles after the start strobe.
- `sin` is ignored whenever `sin_en`=0.

## Configuration
- `FIVE_BIT_DESER_PARITY_EN` defined: PAR state exists, frames carry an even-parity bit, and a parity mismatch drops the frame with a `frame_err` pulse.
- Macro undefined: no PAR state and no parity logic. Frame is start, 5 data bits, stop.

## Test plan
- Reset asserted mid-DATA (after 3 data bits), then released -> all outputs 0, state IDLE. A following clean frame for 5'h0B is received correctly.
- Clean frame for 5'h15 (start 0; data 1,0,1,0,1; parity 1 if enabled; stop 1) on consecutive strobes with `word_ready`=0 -> `word`=5'h15, `word_valid`=1 held for 10 cycles. Raising `word_ready` clears `word_valid` the next cycle.
- Frame for 5'h0A with stop bit 0 -> single-cycle `frame_err`, `word_valid` stays 0, `word` keeps its prior value.
- Macro defined: 5'h07 sent with parity bit 0 (correct value 1) -> `frame_err` pulse, no `word_valid`. Resend with parity 1 -> `word`=5'h07.
- Held word 5'h1F, no ready, new start bit -> `overrun` pulse, `word` still 5'h1F. Remaining bits of that frame produce no new word.
- Held word 5'h01; `word_ready` and a start strobe in the same cycle, followed by a frame for 5'h1E -> transfer of 5'h01, no overrun, then `word`=5'h1E valid.

Source files
------------

// File: rtl/five_bit_deser.sv
// Framed serial-to-parallel receiver: start bit, five data bits LSB first, optional
// even parity (enabled by defining FIVE_BIT_DESER_PARITY_EN), stop bit; valid/ready output.
module five_bit_deser (
    input  logic       clock,
    input  logic       Reset,
    input  logic       sin,
    input  logic       sin_en,
    input  logic       word_ready,
    output logic [4:0] word,
    output logic       word_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

`ifdef FIVE_BIT_DESER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        PAR  = 3'd2,
        STOP = 3'd3,
        HOLD = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        STOP = 3'd3,
        HOLD = 3'd4
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] shreg_q, shreg_d;
    logic [4:0] word_q, word_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;
    logic       start;

    assign start = sin_en & ~sin;

    // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                end
            end
            DATA: begin
                if (sin_en) begin
                    shreg_d = {sin, shreg_q[4:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
`ifdef FIVE_BIT_DESER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef FIVE_BIT_DESER_PARITY_EN
            PAR: begin
                if (sin_en) begin
                    if (sin == ^shreg_q) begin
                        state_d = STOP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            STOP: begin
                if (sin_en) begin
                    if (sin) begin
                        word_d  = shreg_q;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                // A start bit coinciding with the transfer begins the next frame at once.
                if (word_ready) begin
                    if (start) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shreg_q <= 5'd0;
            word_q  <= 5'd0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word       = word_q;
    assign word_valid = (state_q == HOLD);
    assign frame_err  = err_q;
    assign overrun    = ovr_q;
`ifdef FIVE_BIT_DESER_PARITY_EN
    assign busy       = (state_q == DATA) || (state_q == PAR) || (state_q == STOP);
`else
    assign busy       = (state_q == DATA) || (state_q == STOP);
`endif

endmodule

// File: tb/tb_five_bit_deser.sv
// Self-checking bench for five_bit_deser: frame table, directed corner sequences,
// and random traffic against a per-cycle queue-based frame model.
module tb_five_bit_deser;

`ifdef FIVE_BIT_DESER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       sin = 1'b1;
    logic       sin_en = 1'b0;
    logic       word_ready = 1'b0;
    logic [4:0] word;
    logic       word_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    five_bit_deser dut (
        .clock      (clock),
        .Reset      (Reset),
        .sin        (sin),
        .sin_en     (sin_en),
        .word_ready (word_ready),
        .word       (word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is a queue of bits collected after the start bit.
    logic       m_in_frame = 1'b0;
    logic       m_held = 1'b0;
    logic [4:0] m_word = 5'd0;
    logic       m_err = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_bits[$];

    always @(posedge clock or posedge Reset) begin
        if (Reset) begin
            m_in_frame = 1'b0;
            m_held     = 1'b0;
            m_word     = 5'd0;
            m_err      = 1'b0;
            m_ovr      = 1'b0;
            m_bits.delete();
        end else begin
            logic [4:0] d;
            m_err = 1'b0;
            m_ovr = 1'b0;
            if (m_held) begin
                if (word_ready) begin
                    m_held = 1'b0;
                    if (sin_en && !sin) begin
                        m_in_frame = 1'b1;
                        m_bits.delete();
                    end
                end else if (sin_en && !sin) begin
                    m_ovr = 1'b1;
                end
            end else if (!m_in_frame) begin
                if (sin_en && !sin) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                end
            end else if (sin_en) begin
                m_bits.push_back(sin);
                d = 5'd0;
                if (m_bits.size() >= 5)
                    for (int i = 0; i < 5; i++) d[i] = m_bits[i];
                if (PAR_BITS == 1 && m_bits.size() == 6 && m_bits[5] != ^d) begin
                    m_err      = 1'b1;
                    m_in_frame = 1'b0;
                end else if (m_bits.size() == 6 + PAR_BITS) begin
                    m_in_frame = 1'b0;
                    if (m_bits[m_bits.size() - 1]) begin
                        m_word = d;
                        m_held = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        check("scoreboard {word,valid,err,ovr,busy}",
              {7'd0, word, word_valid, frame_err, overrun, busy},
              {7'd0, m_word, m_held, m_err, m_ovr, m_in_frame});
    end

    task automatic drive(input logic en, input logic s, input logic r);
        sin_en     = en;
        sin        = s;
        word_ready = r;
        @(posedge clock);
        #1;
    endtask

    task automatic send_body(input logic [4:0] d, input logic pflip, input logic stop,
                             output logic err_seen);
        err_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, d[i], 1'b0);
            err_seen |= frame_err;
        end
        if (PAR_BITS == 1) begin
            drive(1'b1, (^d) ^ pflip, 1'b0);
            err_seen |= frame_err;
        end
        drive(1'b1, stop, 1'b0);
        err_seen |= frame_err;
    endtask

    task automatic send_frame(input logic [4:0] d, input logic pflip, input logic stop,
                              output logic err_seen);
        drive(1'b1, 1'b0, 1'b0);
        send_body(d, pflip, stop, err_seen);
    endtask

    typedef struct {
        logic [4:0] data;
        logic       par_flip;
        logic       stop;
        int         hold_cycles;
        logic       exp_valid;
        logic       exp_err;
        logic [4:0] exp_word;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic e;
        vecs[0] = '{5'h15, 1'b0, 1'b1, 10, 1'b1, 1'b0, 5'h15};
        vecs[1] = '{5'h0A, 1'b0, 1'b0, 0,  1'b0, 1'b1, 5'h15};
        if (PAR_BITS == 1) vecs[2] = '{5'h07, 1'b1, 1'b1, 0, 1'b0, 1'b1, 5'h15};
        else               vecs[2] = '{5'h07, 1'b1, 1'b1, 0, 1'b1, 1'b0, 5'h07};
        vecs[3] = '{5'h07, 1'b0, 1'b1, 0,  1'b1, 1'b0, 5'h07};
        vecs[4] = '{5'h00, 1'b0, 1'b1, 2,  1'b1, 1'b0, 5'h00};

        // Reset state, including asynchronous effect
        #12;
        check("reset outputs", {11'd0, word, word_valid, frame_err, overrun, busy}, 16'd0);
        Reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset in the middle of DATA
        drive(1'b1, 1'b0, 1'b0);
        check("busy after start", {15'd0, busy}, 16'd1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        sin_en = 1'b0;
        #2 Reset = 1'b1;
        #1 check("async reset mid-DATA", {11'd0, word, word_valid, frame_err, overrun, busy}, 16'd0);
        #2 Reset = 1'b0;
        @(posedge clock);
        #1;
        send_frame(5'h0B, 1'b0, 1'b1, e);
        check("frame 0B valid", {15'd0, word_valid}, 16'd1);
        check("frame 0B word", {11'd0, word}, 16'h0B);
        drive(1'b0, 1'b0, 1'b1);
        check("frame 0B transferred", {15'd0, word_valid}, 16'd0);

        // Table of whole frames
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop, e);
            check($sformatf("vec%0d valid", v), {15'd0, word_valid}, {15'd0, vecs[v].exp_valid});
            check($sformatf("vec%0d err", v), {15'd0, e}, {15'd0, vecs[v].exp_err});
            check($sformatf("vec%0d word", v), {11'd0, word}, {11'd0, vecs[v].exp_word});
            for (int c = 0; c < vecs[v].hold_cycles; c++) begin
                drive(1'b0, 1'b0, 1'b0);
                check($sformatf("vec%0d held", v), {10'd0, word, word_valid}, {10'd0, vecs[v].exp_word, 1'b1});
            end
            if (vecs[v].exp_valid) begin
                drive(1'b0, 1'b0, 1'b1);
                check($sformatf("vec%0d valid drop", v), {15'd0, word_valid}, 16'd0);
            end
        end

        // Overrun while holding 1F
        send_frame(5'h1F, 1'b0, 1'b1, e);
        drive(1'b1, 1'b0, 1'b0);
        check("overrun pulse", {15'd0, overrun}, 16'd1);
        check("overrun word kept", {10'd0, word, word_valid}, {10'd0, 5'h1F, 1'b1});
        send_body(5'h1E, 1'b0, 1'b1, e);
        drive(1'b0, 1'b0, 1'b0);
        check("overrun no new word", {10'd0, word, word_valid}, {10'd0, 5'h1F, 1'b1});
        check("overrun ends", {15'd0, overrun}, 16'd0);
        drive(1'b0, 1'b0, 1'b1);
        check("overrun transfer", {15'd0, word_valid}, 16'd0);

        // Transfer and start bit in the same cycle
        send_frame(5'h01, 1'b0, 1'b1, e);
        check("word 01", {10'd0, word, word_valid}, {10'd0, 5'h01, 1'b1});
        drive(1'b1, 1'b0, 1'b1);
        check("xfer+start no overrun", {13'd0, overrun, word_valid, busy}, 16'b001);
        send_body(5'h1E, 1'b0, 1'b1, e);
        check("word 1E after back-to-back", {10'd0, word, word_valid}, {10'd0, 5'h1E, 1'b1});
        drive(1'b0, 1'b0, 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end
        drive(1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
